pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after a load completes.
REQ-002 The block SHALL have parameter IMEM_DEPTH, default 20, giving the instruction memory size in 32-bit words.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
REQ-004 Load-side ports SHALL be:
- load_valid  in  1  upload word present
- load_data  in  32  upload word
- load_done  in  1  upload finished
- load_en  in  1  re-enter upload from HALT
REQ-005 Control and execute-side ports SHALL be:
- stall  in  1  freeze PC
- branch_taken  in  1  sb_type with condition true
- jal  in  1  uj_type jump
- jalr  in  1  register jump
- imm  in  32  sign-extended immediate
- rs1_data  in  32  jalr base
REQ-006 Instruction-memory write ports SHALL be:
- imem_wr_en  out  1  write strobe
- imem_wr_addr  out  32  byte address
- imem_wr_data  out  32  write word
REQ-007 Fetch and status ports SHALL be:
- pc_o  out  32  fetch address to instruction memory pci
- pc_plus4  out  32  link value
- fetch_valid  out  1  pc_o is valid
- state_o  out  2  current state
- trap_cause  out  2  00 none, 01 misaligned target, 10 out of range
- load_ovf  out  1  sticky upload overflow

Function
REQ-008 The FSM SHALL have three states: LOAD=0, RUN=1, HALT=2.
REQ-009 FSM transitions SHALL be:
- LOAD -> RUN on load_done
- RUN -> HALT on trap
- HALT -> LOAD on load_en
- all other inputs hold the state
REQ-010 In LOAD, each load_valid cycle SHALL register imem_wr_en=1, imem_wr_data=load_data and imem_wr_addr=word_cnt*4 for the following cycle only, then increment word_cnt.
REQ-011 When word_cnt==IMEM_DEPTH, further load_valid SHALL be dropped with no write and SHALL set load_ovf; load_ovf clears only on reset or on the HALT->LOAD transition.
REQ-012 If load_valid and load_done are asserted together, the block SHALL perform the write and enter RUN on the same edge.
REQ-013 On the LOAD->RUN edge, pc_o SHALL be set to RESET_PC.
REQ-014 In RUN with stall=0, next PC priority SHALL be:
- jalr: (rs1_data+imm) & ~32'h1
- jal: pc_o+imm
- branch_taken: pc_o+imm
- otherwise pc_o+4
REQ-015 All PC sums SHALL be 32-bit modulo 2^32.
REQ-016 stall=1 SHALL hold pc_o and SHALL discard any redirect in that cycle; the producer holds redirects until stall=0.
REQ-017 A next PC with bits[1:0]!=0 SHALL be a trap with trap_cause=01.
REQ-018 A next PC >= IMEM_DEPTH*4 SHALL be a trap with trap_cause=10.
REQ-019 If both trap conditions hold, trap_cause SHALL be 01.
REQ-020 On a trap, pc_o SHALL keep the faulting instruction's PC and the FSM SHALL enter HALT.
REQ-021 fetch_valid SHALL be 1 only in RUN.
REQ-022 pc_plus4 SHALL equal pc_o+4 combinationally.
REQ-023 pc_o SHALL update one cycle after the cycle its inputs are sampled.
REQ-024 load_en outside HALT SHALL be ignored.
REQ-025 HALT->LOAD SHALL clear word_cnt and trap_cause.

Reset
REQ-026 rst_n low SHALL set asynchronously:
- state LOAD
- pc_o RESET_PC
- word_cnt 0
- imem_wr_en 0, imem_wr_addr 0, imem_wr_data 0
- trap_cause 00, load_ovf 0
- fetch_valid 0
REQ-027 Reset asserted mid-upload or mid-run SHALL abort immediately with no further write strobe.
REQ-028 Reset deassertion SHALL be synchronised externally.

Structure
REQ-029 A shared package SHALL hold the state enum, the trap_cause encoding, and constants PC_STEP=4 and ALIGN_MASK.
REQ-030 The next-PC selection and trap check SHALL be one combinational sub-module, pc_next_sel; the FSM, counter and registers SHALL stay in pc_gen.

Verification
REQ-031 The bench SHALL cover at least these directed scenarios:
- Upload 3 words 0x13,0x93,0x113 then load_done -> writes at 0x0, 0x4, 0x8; RUN; pc_o sequence 0x0, 0x4, 0x8.
- RUN pc_o=0x8, jal=1, branch_taken=1, imm=0xFFFFFFF8 -> next pc_o=0x0; with stall=1 same cycle -> pc_o stays 0x8.
- jalr, rs1_data=0x11, imm=0x2 -> pc 0x12 -> misaligned trap: trap_cause=01, HALT, pc_o unchanged.
- pc_o=0x4C (last word, depth 20), no redirect -> 0x50 -> trap_cause=10, HALT.
- Upload 21 words -> 20 writes, load_ovf=1; load_valid+load_done same cycle -> write happens and RUN entered.
- rst_n low during RUN at pc_o=0x20 -> immediate LOAD, pc_o=0x0, fetch_valid=0.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the program-counter generator.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        TRAP_NONE     = 2'b00,
        TRAP_MISALIGN = 2'b01,
        TRAP_RANGE    = 2'b10
    } trap_cause_t;

    localparam logic [31:0] PC_STEP    = 32'd4;
    // Low address bits that must be zero for a word-aligned fetch.
    localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;
    // jalr target has bit 0 forced low before the alignment check.
    localparam logic [31:0] JALR_MASK  = ~32'h0000_0001;

endpackage

// File: rtl/pc_gen_next_sel.sv
// Combinational next-PC selection and trap classification.
module pc_next_sel
    import pc_gen_pkg::*;
#(
    parameter int IMEM_DEPTH = 20
) (
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    output logic [31:0] next_pc,
    output logic        trap,
    output logic [1:0]  cause
);

    localparam logic [31:0] IMEM_BYTES = 32'(IMEM_DEPTH) * PC_STEP;

    trap_cause_t cause_e;

    // Redirect priority: jalr, then jal/branch, then sequential step.
    always_comb begin
        next_pc = pc + PC_STEP;
        if (jalr) begin
            next_pc = (rs1_data + imm) & JALR_MASK;
        end else if (jal || branch_taken) begin
            next_pc = pc + imm;
        end
    end

    // Misalignment wins over out-of-range when both apply.
    always_comb begin
        cause_e = TRAP_NONE;
        if ((next_pc & ALIGN_MASK) != 32'd0) begin
            cause_e = TRAP_MISALIGN;
        end else if (next_pc >= IMEM_BYTES) begin
            cause_e = TRAP_RANGE;
        end
    end

    assign cause = cause_e;
    assign trap  = (cause_e != TRAP_NONE);

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: instruction upload, fetch sequencing, trap halt.
//
// state | meaning
// LOAD  | accepting upload words into instruction memory
// RUN   | fetching; PC advances or redirects each unstalled cycle
// HALT  | trapped; PC frozen at faulting instruction until load_en
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_done,
    input  logic        load_en,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    output logic        imem_wr_en,
    output logic [31:0] imem_wr_addr,
    output logic [31:0] imem_wr_data,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic [1:0]  state_o,
    output logic [1:0]  trap_cause,
    output logic        load_ovf
);

    localparam int CNT_W = $clog2(IMEM_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(IMEM_DEPTH);

    state_t           state;
    logic [CNT_W-1:0] word_cnt;
    logic [31:0]      next_pc;
    logic             trap;
    logic [1:0]       cause;

    pc_next_sel #(
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_next_sel (
        .pc           (pc_o),
        .branch_taken (branch_taken),
        .jal          (jal),
        .jalr         (jalr),
        .imm          (imm),
        .rs1_data     (rs1_data),
        .next_pc      (next_pc),
        .trap         (trap),
        .cause        (cause)
    );

    assign pc_plus4 = pc_o + PC_STEP;
    assign state_o  = state;

    // Sequencing FSM with upload counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_LOAD;
            pc_o         <= RESET_PC;
            word_cnt     <= '0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= 32'd0;
            imem_wr_data <= 32'd0;
            trap_cause   <= TRAP_NONE;
            load_ovf     <= 1'b0;
            fetch_valid  <= 1'b0;
        end else begin
            imem_wr_en <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (load_valid) begin
                        if (word_cnt != CNT_FULL) begin
                            imem_wr_en   <= 1'b1;
                            imem_wr_addr <= 32'(word_cnt) * PC_STEP;
                            imem_wr_data <= load_data;
                            word_cnt     <= word_cnt + 1'b1;
                        end else begin
                            load_ovf <= 1'b1;
                        end
                    end
                    if (load_done) begin
                        state       <= ST_RUN;
                        pc_o        <= RESET_PC;
                        fetch_valid <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (trap) begin
                            state       <= ST_HALT;
                            trap_cause  <= cause;
                            fetch_valid <= 1'b0;
                        end else begin
                            pc_o <= next_pc;
                        end
                    end
                end
                ST_HALT: begin
                    if (load_en) begin
                        state      <= ST_LOAD;
                        word_cnt   <= '0;
                        trap_cause <= TRAP_NONE;
                        load_ovf   <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_LOAD;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen with a behavioural reference model.
module tb_pc_gen;

    localparam int          DEPTH = 20;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid, load_done, load_en;
    logic [31:0] load_data;
    logic        stall, branch_taken, jal, jalr;
    logic [31:0] imm, rs1_data;
    logic        imem_wr_en;
    logic [31:0] imem_wr_addr, imem_wr_data;
    logic [31:0] pc_o, pc_plus4;
    logic        fetch_valid;
    logic [1:0]  state_o, trap_cause;
    logic        load_ovf;

    int checks = 0;
    int failures = 0;

    // Reference model state (0=LOAD 1=RUN 2=HALT).
    int          m_state;
    logic [31:0] m_pc;
    int          m_cnt;
    logic        m_ovf;
    logic [1:0]  m_cause;
    logic        m_wr_en;
    logic [31:0] m_wr_addr, m_wr_data;

    pc_gen #(.RESET_PC(RPC), .IMEM_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_done    (load_done),
        .load_en      (load_en),
        .stall        (stall),
        .branch_taken (branch_taken),
        .jal          (jal),
        .jalr         (jalr),
        .imm          (imm),
        .rs1_data     (rs1_data),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .pc_o         (pc_o),
        .pc_plus4     (pc_plus4),
        .fetch_valid  (fetch_valid),
        .state_o      (state_o),
        .trap_cause   (trap_cause),
        .load_ovf     (load_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_target(logic [31:0] pc);
        logic [31:0] t;
        if (jalr)                     t = (rs1_data + imm) & 32'hFFFF_FFFE;
        else if (jal || branch_taken) t = pc + imm;
        else                          t = pc + 32'd4;
        return t;
    endfunction

    task automatic model_reset();
        m_state = 0; m_pc = RPC; m_cnt = 0; m_ovf = 1'b0; m_cause = 2'b00;
        m_wr_en = 1'b0; m_wr_addr = 32'd0; m_wr_data = 32'd0;
    endtask

    task automatic idle_inputs();
        load_valid = 0; load_done = 0; load_en = 0; load_data = 32'd0;
        stall = 0; branch_taken = 0; jal = 0; jalr = 0; imm = 32'd0; rs1_data = 32'd0;
    endtask

    // Advance the model with the currently driven inputs, then clock the DUT.
    task automatic tick();
        logic [31:0] t;
        m_wr_en = 1'b0;
        case (m_state)
            0: begin
                if (load_valid) begin
                    if (m_cnt < DEPTH) begin
                        m_wr_en = 1'b1; m_wr_addr = m_cnt * 4; m_wr_data = load_data;
                        m_cnt++;
                    end else m_ovf = 1'b1;
                end
                if (load_done) begin m_state = 1; m_pc = RPC; end
            end
            1: if (!stall) begin
                t = ref_target(m_pc);
                if (t % 4 != 0)       begin m_cause = 2'b01; m_state = 2; end
                else if (t >= DEPTH * 4) begin m_cause = 2'b10; m_state = 2; end
                else m_pc = t;
            end
            default: if (load_en) begin m_state = 0; m_cnt = 0; m_cause = 2'b00; m_ovf = 1'b0; end
        endcase
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        #12 rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (state_o !== 2'd0)       begin failures++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        if (pc_o !== RPC)           begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc_o, RPC); end
        if (imem_wr_en !== 1'b0 || imem_wr_addr !== 32'd0 || imem_wr_data !== 32'd0)
                                    begin failures++; $display("FAIL reset_wr got=%b/%h/%h exp=0/0/0", imem_wr_en, imem_wr_addr, imem_wr_data); end
        if (trap_cause !== 2'b00)   begin failures++; $display("FAIL reset_cause got=%b exp=00", trap_cause); end
        if (load_ovf !== 1'b0)      begin failures++; $display("FAIL reset_ovf got=%b exp=0", load_ovf); end
        if (fetch_valid !== 1'b0)   begin failures++; $display("FAIL reset_fv got=%b exp=0", fetch_valid); end
    endtask

    task automatic test_upload_and_step();
        logic [31:0] words [3];
        words[0] = 32'h13; words[1] = 32'h93; words[2] = 32'h113;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1; load_data = words[i];
            tick();
            checks++;
            if (imem_wr_en !== 1'b1 || imem_wr_addr !== 32'(i * 4) || imem_wr_data !== words[i]) begin
                failures++;
                $display("FAIL upload_w%0d got=%b/%h/%h exp=1/%h/%h", i, imem_wr_en, imem_wr_addr, imem_wr_data, 32'(i * 4), words[i]);
            end
        end
        load_valid = 0; load_done = 1;
        tick();
        load_done = 0;
        checks += 2;
        if (imem_wr_en !== 1'b0) begin failures++; $display("FAIL strobe_one_cycle got=%b exp=0", imem_wr_en); end
        if (state_o !== 2'd1 || fetch_valid !== 1'b1 || pc_o !== 32'h0) begin
            failures++; $display("FAIL enter_run got=st%0d fv%b pc%h exp=st1 fv1 pc0", state_o, fetch_valid, pc_o);
        end
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++;
            if (pc_o !== 32'(i * 4) || pc_plus4 !== 32'(i * 4 + 4)) begin
                failures++; $display("FAIL step_%0d got=%h/%h exp=%h/%h", i, pc_o, pc_plus4, 32'(i * 4), 32'(i * 4 + 4));
            end
        end
    endtask

    task automatic test_redirect_stall();
        jal = 1; branch_taken = 1; imm = 32'hFFFF_FFF8; stall = 1;
        tick();
        checks++;
        if (pc_o !== 32'h8) begin failures++; $display("FAIL stall_hold got=%h exp=00000008", pc_o); end
        stall = 0;
        tick();
        idle_inputs();
        checks++;
        if (pc_o !== 32'h0) begin failures++; $display("FAIL jal_back got=%h exp=00000000", pc_o); end
    endtask

    task automatic test_misalign();
        jalr = 1; jal = 1; rs1_data = 32'h11; imm = 32'h2;
        tick();
        idle_inputs();
        checks += 2;
        if (trap_cause !== 2'b01 || state_o !== 2'd2) begin
            failures++; $display("FAIL misalign got=cause%b st%0d exp=cause01 st2", trap_cause, state_o);
        end
        if (pc_o !== 32'h0 || fetch_valid !== 1'b0) begin
            failures++; $display("FAIL misalign_pc got=%h fv%b exp=00000000 fv0", pc_o, fetch_valid);
        end
    endtask

    task automatic test_range();
        load_en = 1; tick(); load_en = 0;
        checks++;
        if (state_o !== 2'd0 || trap_cause !== 2'b00) begin
            failures++; $display("FAIL halt_to_load got=st%0d cause%b exp=st0 cause00", state_o, trap_cause);
        end
        load_done = 1; tick(); load_done = 0;
        for (int i = 0; i < 19; i++) tick();
        checks++;
        if (pc_o !== 32'h4C) begin failures++; $display("FAIL reach_last got=%h exp=0000004c", pc_o); end
        tick();
        checks++;
        if (trap_cause !== 2'b10 || state_o !== 2'd2 || pc_o !== 32'h4C) begin
            failures++; $display("FAIL range_trap got=cause%b st%0d pc%h exp=cause10 st2 pc4c", trap_cause, state_o, pc_o);
        end
    endtask

    task automatic test_overflow();
        int writes;
        load_en = 1; tick(); load_en = 0;
        writes = 0;
        for (int i = 0; i < 21; i++) begin
            load_valid = 1; load_data = $urandom;
            tick();
            if (imem_wr_en === 1'b1) writes++;
        end
        load_valid = 0;
        checks += 2;
        if (writes != 20)     begin failures++; $display("FAIL ovf_writes got=%0d exp=20", writes); end
        if (load_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", load_ovf); end
        load_done = 1; tick(); load_done = 0;
        checks++;
        if (load_ovf !== 1'b1 || state_o !== 2'd1) begin
            failures++; $display("FAIL ovf_sticky got=ovf%b st%0d exp=ovf1 st1", load_ovf, state_o);
        end
        jalr = 1; rs1_data = 32'h1000; tick(); idle_inputs();
        load_en = 1; tick(); load_en = 0;
        checks++;
        if (load_ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", load_ovf); end
        load_valid = 1; load_done = 1; load_data = 32'hCAFE_0013;
        tick();
        idle_inputs();
        checks++;
        if (imem_wr_en !== 1'b1 || imem_wr_addr !== 32'h0 || imem_wr_data !== 32'hCAFE_0013 || state_o !== 2'd1) begin
            failures++; $display("FAIL valid_done_same got=%b/%h/%h st%0d exp=1/0/cafe0013 st1", imem_wr_en, imem_wr_addr, imem_wr_data, state_o);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            idle_inputs();
            load_valid   = ($urandom_range(0, 1) == 1);
            load_data    = $urandom;
            load_done    = (m_state == 0) && ($urandom_range(0, 7) == 0);
            load_en      = ($urandom_range(0, 2) == 0);
            stall        = ($urandom_range(0, 3) == 0);
            jalr         = ($urandom_range(0, 7) == 0);
            jal          = ($urandom_range(0, 7) == 0);
            branch_taken = ($urandom_range(0, 3) == 0);
            imm          = ($urandom_range(0, 9) == 0) ? 32'h2 : (32'($urandom_range(0, 15)) * 4 - 32'd32);
            rs1_data     = 32'($urandom_range(0, 80));
            tick();
            checks++;
            if (pc_o !== m_pc || state_o !== 2'(m_state) || trap_cause !== m_cause ||
                fetch_valid !== (m_state == 1) || load_ovf !== m_ovf || imem_wr_en !== m_wr_en ||
                (m_wr_en && (imem_wr_addr !== m_wr_addr || imem_wr_data !== m_wr_data)) ||
                pc_plus4 !== m_pc + 32'd4) begin
                failures++;
                $display("FAIL random_%0d got=pc%h st%0d cause%b fv%b ovf%b we%b exp=pc%h st%0d cause%b fv%b ovf%b we%b",
                         n, pc_o, state_o, trap_cause, fetch_valid, load_ovf, imem_wr_en,
                         m_pc, m_state, m_cause, (m_state == 1), m_ovf, m_wr_en);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        load_done = 1; tick(); load_done = 0;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (pc_o !== 32'h20) begin failures++; $display("FAIL run_to_20 got=%h exp=00000020", pc_o); end
        #2 rst_n = 0;
        #1;
        model_reset();
        checks++;
        if (state_o !== 2'd0 || pc_o !== 32'h0 || fetch_valid !== 1'b0) begin
            failures++; $display("FAIL async_reset_run got=st%0d pc%h fv%b exp=st0 pc0 fv0", state_o, pc_o, fetch_valid);
        end
        #10 rst_n = 1;
        @(negedge clk);
        load_valid = 1; load_data = 32'h55; tick();
        #2 rst_n = 0;
        #1;
        checks++;
        if (imem_wr_en !== 1'b0) begin failures++; $display("FAIL async_reset_load got=%b exp=0", imem_wr_en); end
        idle_inputs();
        #10 rst_n = 1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1;
        test_reset();
        test_upload_and_step();
        test_redirect_stall();
        test_misalign();
        test_range();
        test_overflow();
        test_random();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
